// File: rtl/line_fill_unit.sv
// rtl/line_fill_unit.sv - single-outstanding cache line fill engine with store merge.
// Optional early-restart critical-beat output: LINE_FILL_EARLY_RESTART_EN.
module line_fill_unit #(
  parameter int ADDR_WIDTH = 32,
  parameter int LINE_SIZE  = 64,
  parameter int TAG_WIDTH  = 19,
  parameter int BEAT_WIDTH = 64,
  localparam int NBEATS    = LINE_SIZE * 8 / BEAT_WIDTH,
  localparam int CW        = $clog2(NBEATS),
  localparam int SW        = BEAT_WIDTH / 8
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    req_valid,
  output logic                    req_ready,
  input  logic [ADDR_WIDTH-1:0]   req_addr,
  input  logic                    req_wr,
  input  logic [CW-1:0]           req_wr_beat,
  input  logic [BEAT_WIDTH-1:0]   req_wr_data,
  input  logic [SW-1:0]           req_wr_strb,
`ifdef LINE_FILL_EARLY_RESTART_EN
  input  logic [CW-1:0]           req_crit_beat,
  output logic                    crit_valid,
  output logic [BEAT_WIDTH-1:0]   crit_data,
`endif
  output logic                    mem_req_valid,
  input  logic                    mem_req_ready,
  output logic [ADDR_WIDTH-1:0]   mem_req_addr,
  input  logic                    mem_rsp_valid,
  output logic                    mem_rsp_ready,
  input  logic [BEAT_WIDTH-1:0]   mem_rsp_data,
  input  logic                    mem_rsp_err,
  output logic                    line_we,
  output logic                    line_valid,
  output logic                    line_dirty,
  output logic [TAG_WIDTH-1:0]    line_tag,
  output logic [LINE_SIZE*8-1:0]  line_data,
  output logic                    fill_done,
  output logic                    fill_err
);

  typedef enum logic [1:0] {IDLE, REQ, RECV, WRITE} state_t;

  state_t                             state;
  logic [CW-1:0]                      beat_cnt;
  logic                               wr;
  logic [CW-1:0]                      wr_beat;
  logic [BEAT_WIDTH-1:0]              wr_data;
  logic [SW-1:0]                      wr_strb;
  logic [NBEATS-1:0][BEAT_WIDTH-1:0]  line_buf;
  logic [NBEATS-1:0][BEAT_WIDTH-1:0]  next_buf;
  logic [BEAT_WIDTH-1:0]              merged;
  logic                               rsp_fire;
  logic                               last_beat;
`ifdef LINE_FILL_EARLY_RESTART_EN
  logic [CW-1:0]                      crit_beat;
`endif

  assign rsp_fire  = mem_rsp_valid && mem_rsp_ready;
  assign last_beat = (beat_cnt == CW'(NBEATS - 1));

  // Store bytes override memory bytes only on the targeted beat of a store fill.
  always_comb begin
    merged = mem_rsp_data;
    for (int i = 0; i < SW; i++) begin
      if (wr && (beat_cnt == wr_beat) && wr_strb[i]) begin
        merged[i*8 +: 8] = wr_data[i*8 +: 8];
      end
    end
    next_buf           = line_buf;
    next_buf[beat_cnt] = merged;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= IDLE;
      beat_cnt      <= '0;
      wr            <= 1'b0;
      wr_beat       <= '0;
      wr_data       <= '0;
      wr_strb       <= '0;
      line_buf      <= '0;
      req_ready     <= 1'b1;
      mem_req_valid <= 1'b0;
      mem_req_addr  <= '0;
      mem_rsp_ready <= 1'b0;
      line_we       <= 1'b0;
      line_valid    <= 1'b0;
      line_dirty    <= 1'b0;
      line_tag      <= '0;
      line_data     <= '0;
      fill_done     <= 1'b0;
      fill_err      <= 1'b0;
`ifdef LINE_FILL_EARLY_RESTART_EN
      crit_beat     <= '0;
      crit_valid    <= 1'b0;
      crit_data     <= '0;
`endif
    end else begin
      line_we    <= 1'b0;
      line_valid <= 1'b0;
      line_dirty <= 1'b0;
      fill_done  <= 1'b0;
      fill_err   <= 1'b0;
`ifdef LINE_FILL_EARLY_RESTART_EN
      crit_valid <= 1'b0;
`endif
      case (state)
        IDLE: begin
          if (req_valid) begin
            mem_req_addr  <= req_addr & ~ADDR_WIDTH'(LINE_SIZE - 1);
            wr            <= req_wr;
            wr_beat       <= req_wr_beat;
            wr_data       <= req_wr_data;
            wr_strb       <= req_wr_strb;
`ifdef LINE_FILL_EARLY_RESTART_EN
            crit_beat     <= req_crit_beat;
`endif
            beat_cnt      <= '0;
            req_ready     <= 1'b0;
            mem_req_valid <= 1'b1;
            state         <= REQ;
          end
        end
        REQ: begin
          if (mem_req_ready) begin
            mem_req_valid <= 1'b0;
            mem_rsp_ready <= 1'b1;
            state         <= RECV;
          end
        end
        RECV: begin
          if (rsp_fire) begin
            if (mem_rsp_err) begin
              // The errored beat is dropped and the line is never written.
              mem_rsp_ready <= 1'b0;
              req_ready     <= 1'b1;
              fill_err      <= 1'b1;
              state         <= IDLE;
            end else begin
              line_buf <= next_buf;
              beat_cnt <= beat_cnt + CW'(1);
`ifdef LINE_FILL_EARLY_RESTART_EN
              if (beat_cnt == crit_beat) begin
                crit_valid <= 1'b1;
                crit_data  <= merged;
              end
`endif
              if (last_beat) begin
                mem_rsp_ready <= 1'b0;
                line_we       <= 1'b1;
                line_valid    <= 1'b1;
                line_dirty    <= wr;
                line_tag      <= mem_req_addr[ADDR_WIDTH-1 -: TAG_WIDTH];
                line_data     <= next_buf;
                fill_done     <= 1'b1;
                state         <= WRITE;
              end
            end
          end
        end
        WRITE: begin
          req_ready <= 1'b1;
          state     <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
